cpu_data_responder: RTL and testbench

// - Responder for the CPU data port: serves every load/store issued by the memory stage.
// - Zero-wait-state: the port has no stall, so read data is combinational from data_addr.

---
 rtl/cpu_data_responder_pkg.sv | 38 +++
 rtl/cpu_data_responder_if.sv | 20 ++
 rtl/cpu_data_responder_console_fifo.sv | 53 +++++
 rtl/cpu_data_responder.sv | 145 ++++++++++++++
 tb/tb_cpu_data_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_data_responder_pkg.sv
// Shared address map, MMIO register indices and status bit positions for the
// CPU data-port responder, plus the byte-lane merge helper.
package cpu_data_responder_pkg;

    localparam logic [3:0] RAM_REGION  = 4'h1;
    localparam logic [3:0] MMIO_REGION = 4'h2;

    // MMIO register indices, i.e. byte offset >> 2
    localparam logic [5:0] MMIO_MTIME_LO    = 6'h00;
    localparam logic [5:0] MMIO_MTIME_HI    = 6'h01;
    localparam logic [5:0] MMIO_MTIMECMP_LO = 6'h02;
    localparam logic [5:0] MMIO_MTIMECMP_HI = 6'h03;
    localparam logic [5:0] MMIO_CON_DATA    = 6'h04;
    localparam logic [5:0] MMIO_CON_STATUS  = 6'h05;

    localparam int CON_ST_FULL  = 0;
    localparam int CON_ST_EMPTY = 1;
    localparam int CON_ST_OVF   = 2;
    localparam int CON_ST_COUNT = 3;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_RAM  = 2'd1,
        TGT_MMIO = 2'd2
    } target_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_data_responder_if.sv
// CPU data port (zero-wait load/store) and console byte stream bundled together.
interface cpu_data_responder_if;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wenable;
    logic [31:0] data_rdata;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    modport master (
        output data_addr, data_wdata, data_wenable, con_ready,
        input  data_rdata, con_data, con_valid
    );

    modport slave (
        input  data_addr, data_wdata, data_wenable, con_ready,
        output data_rdata, con_data, con_valid
    );
endinterface

// File: rtl/cpu_data_responder_console_fifo.sv
// Console TX FIFO: wrap-bit pointers, unreset storage, valid/ready drain side.
module cpu_console_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_push,
    input  logic [7:0]                      i_wdata,
    output logic                            o_full,
    output logic                            o_empty,
    output logic [$clog2(FIFO_DEPTH):0]     o_count,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [7:0]                      o_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]  w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_push_ok;

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = !w_empty && i_ready;
    // A pop in the same cycle frees the slot a full-FIFO push lands in
    assign w_push_ok = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = w_count;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/cpu_data_responder.sv
// Zero-wait responder for the CPU data port: byte-writable RAM, 64-bit machine
// timer with compare interrupt, and a console TX FIFO behind MMIO.
module cpu_data_responder
    import cpu_data_responder_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int PRESCALE   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    cpu_data_responder_if.slave  bus,
    output logic                 o_timer_irq,
    output logic                 o_bus_err
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [PS_W-1:0]   r_prescale;
    logic [31:0]       r_mtime_lo, r_mtime_hi, r_mtcmp_lo, r_mtcmp_hi;
    logic              r_timer_irq, r_ovf, r_bus_err;

    target_e           w_tgt;
    logic [5:0]        w_reg;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr, w_mmio_wr, w_ram_wr;
    logic              w_wr_mtlo, w_wr_mthi, w_wr_cmplo, w_wr_cmphi, w_wr_status;
    logic              w_push, w_pop, w_tick, w_lo_carry;
    logic              w_full, w_empty;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_status, w_rdata;
    logic              w_unused;

    always_comb begin
        w_tgt = TGT_NONE;
        if (bus.data_addr[31:28] == RAM_REGION)       w_tgt = TGT_RAM;
        else if (bus.data_addr[31:28] == MMIO_REGION) w_tgt = TGT_MMIO;
    end

    assign w_reg       = bus.data_addr[7:2];
    assign w_ram_idx   = bus.data_addr[2 +: RAM_AW];
    assign w_wr        = |bus.data_wenable;
    assign w_ram_wr    = w_wr && (w_tgt == TGT_RAM);
    assign w_mmio_wr   = w_wr && (w_tgt == TGT_MMIO);
    assign w_wr_mtlo   = w_mmio_wr && (w_reg == MMIO_MTIME_LO);
    assign w_wr_mthi   = w_mmio_wr && (w_reg == MMIO_MTIME_HI);
    assign w_wr_cmplo  = w_mmio_wr && (w_reg == MMIO_MTIMECMP_LO);
    assign w_wr_cmphi  = w_mmio_wr && (w_reg == MMIO_MTIMECMP_HI);
    assign w_wr_status = w_mmio_wr && (w_reg == MMIO_CON_STATUS);
    assign w_push      = w_mmio_wr && (w_reg == MMIO_CON_DATA) && bus.data_wenable[0];
    assign w_pop       = bus.con_valid && bus.con_ready;
    assign w_tick      = (r_prescale == PS_W'(PRESCALE - 1));
    assign w_lo_carry  = w_tick && (r_mtime_lo == 32'hFFFF_FFFF);
    assign w_unused    = ^bus.data_addr;

    always_comb begin
        w_status = '0;
        w_status[CON_ST_FULL]       = w_full;
        w_status[CON_ST_EMPTY]      = w_empty;
        w_status[CON_ST_OVF]        = r_ovf;
        w_status[CON_ST_COUNT +: 8] = 8'(w_count);
    end

    always_comb begin
        w_rdata = '0;
        if (w_tgt == TGT_RAM) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_tgt == TGT_MMIO) begin
            case (w_reg)
                MMIO_MTIME_LO:    w_rdata = r_mtime_lo;
                MMIO_MTIME_HI:    w_rdata = r_mtime_hi;
                MMIO_MTIMECMP_LO: w_rdata = r_mtcmp_lo;
                MMIO_MTIMECMP_HI: w_rdata = r_mtcmp_hi;
                MMIO_CON_STATUS:  w_rdata = w_status;
                default:          w_rdata = '0;
            endcase
        end
    end
    assign bus.data_rdata = w_rdata;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_wr && bus.data_wenable[i])
                r_ram[w_ram_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
        end
    end

    // CPU writes win over the tick for the written half; HI still takes the LO carry otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prescale  <= '0;
            r_mtime_lo  <= '0;
            r_mtime_hi  <= '0;
            r_mtcmp_lo  <= 32'hFFFF_FFFF;
            r_mtcmp_hi  <= 32'hFFFF_FFFF;
            r_timer_irq <= 1'b0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_wr_mtlo)
                r_mtime_lo <= byte_merge(r_mtime_lo, bus.data_wdata, bus.data_wenable);
            else if (w_tick)
                r_mtime_lo <= r_mtime_lo + 32'd1;
            if (w_wr_mthi)
                r_mtime_hi <= byte_merge(r_mtime_hi, bus.data_wdata, bus.data_wenable);
            else if (w_lo_carry)
                r_mtime_hi <= r_mtime_hi + 32'd1;
            if (w_wr_cmplo)
                r_mtcmp_lo <= byte_merge(r_mtcmp_lo, bus.data_wdata, bus.data_wenable);
            if (w_wr_cmphi)
                r_mtcmp_hi <= byte_merge(r_mtcmp_hi, bus.data_wdata, bus.data_wenable);
            r_timer_irq <= ({r_mtime_hi, r_mtime_lo} >= {r_mtcmp_hi, r_mtcmp_lo});
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_wr_status)
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            r_bus_err <= w_wr && (w_tgt == TGT_NONE);
        end
    end

    cpu_console_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_con_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (bus.data_wdata[7:0]),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_valid (bus.con_valid),
        .i_ready (bus.con_ready),
        .o_data  (bus.con_data)
    );

    assign o_timer_irq = r_timer_irq;
    assign o_bus_err   = r_bus_err;
endmodule

// File: tb/tb_cpu_data_responder.sv
// Directed bench for cpu_data_responder: RAM lanes, timer/irq, carry priority,
// console FIFO overflow and full push+pop, unmapped writes and async reset.
module tb_cpu_data_responder;
    localparam logic [31:0] A_MTLO   = 32'h2000_0000;
    localparam logic [31:0] A_MTHI   = 32'h2000_0004;
    localparam logic [31:0] A_CMPLO  = 32'h2000_0008;
    localparam logic [31:0] A_CMPHI  = 32'h2000_000C;
    localparam logic [31:0] A_CDATA  = 32'h2000_0010;
    localparam logic [31:0] A_STATUS = 32'h2000_0014;

    logic clk;
    logic rst_n;
    logic timer_irq;
    logic bus_err;
    int   n_checks;
    int   n_errors;

    cpu_data_responder_if bus ();

    cpu_data_responder #(.RAM_WORDS(1024), .PRESCALE(1), .FIFO_DEPTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_timer_irq (timer_irq),
        .o_bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called in the low clock phase; returns at the next falling edge after the write commits
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        bus.data_addr    = a;
        bus.data_wdata   = d;
        bus.data_wenable = w;
        @(negedge clk);
        bus.data_wenable = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.data_addr    = a;
        bus.data_wenable = 4'b0000;
        #1;
        d = bus.data_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] prev;
        logic [7:0]  exp_b [8];

        n_checks = 0;
        n_errors = 0;
        rst_n            = 1'b0;
        bus.data_addr    = '0;
        bus.data_wdata   = '0;
        bus.data_wenable = 4'b0000;
        bus.con_ready    = 1'b0;
        prev             = '0;
        repeat (3) @(negedge clk);

        // reset state
        check_eq("rst_con_valid", {31'b0, bus.con_valid}, 32'd0);
        check_eq("rst_irq", {31'b0, timer_irq}, 32'd0);
        check_eq("rst_bus_err", {31'b0, bus_err}, 32'd0);
        rd(A_STATUS, v); check_eq("rst_status", v, 32'h0000_0002);
        rd(A_MTLO, v);   check_eq("rst_mtime_lo", v, 32'd0);
        rd(A_CMPLO, v);  check_eq("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(A_CMPHI, v);  check_eq("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rst_n = 1'b1;

        // RAM byte lanes and aliasing
        wr(32'h1000_0010, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h1000_0010, 32'h0000_5500, 4'b0010);
        rd(32'h1000_0010, v); check_eq("ram_lane", v, 32'hDEAD_55EF);
        rd(32'h1000_0013, v); check_eq("ram_unaligned", v, 32'hDEAD_55EF);
        rd(32'h1000_1010, v); check_eq("ram_alias", v, 32'hDEAD_55EF);
        bus.data_addr = 32'h1000_0010; bus.data_wdata = 32'h1111_1111; bus.data_wenable = 4'b1111;
        #1 check_eq("ram_read_old_on_write", bus.data_rdata, 32'hDEAD_55EF);
        @(negedge clk); bus.data_wenable = 4'b0000;
        rd(32'h1000_0010, v); check_eq("ram_after_write", v, 32'h1111_1111);

        // timer compare: irq is 1 from the cycle after mtime==20
        wr(A_CMPHI, 32'd0, 4'b1111);
        wr(A_CMPLO, 32'd20, 4'b1111);
        for (int i = 0; i < 30; i++) begin
            rd(A_MTLO, v);
            check_eq("irq_vs_mtime", {31'b0, timer_irq}, {31'b0, (v >= 32'd21)});
            if (i > 0) check_eq("mtime_step", v, prev + 32'd1);
            prev = v;
            @(negedge clk);
        end

        // LO carry into HI, then HI write wins in the carry cycle
        wr(A_MTLO, 32'hFFFF_FFFF, 4'b1111);
        rd(A_MTLO, v); check_eq("carry_lo_pre", v, 32'hFFFF_FFFF);
        rd(A_MTHI, v); check_eq("carry_hi_pre", v, 32'd0);
        @(negedge clk);
        rd(A_MTLO, v); check_eq("carry_lo", v, 32'd0);
        rd(A_MTHI, v); check_eq("carry_hi", v, 32'd1);
        wr(A_MTLO, 32'hFFFF_FFFF, 4'b1111);
        wr(A_MTHI, 32'd7, 4'b1111);
        rd(A_MTHI, v); check_eq("prio_hi", v, 32'd7);
        rd(A_MTLO, v); check_eq("prio_lo", v, 32'd0);

        // console overflow with sink stalled
        for (int i = 0; i < 9; i++) wr(A_CDATA, 32'h41 + i, 4'b0001);
        rd(A_STATUS, v); check_eq("con_full_ovf", v, 32'h0000_0045);
        rd(A_CDATA, v);  check_eq("con_data_read0", v, 32'd0);
        check_eq("con_stall_data", {24'b0, bus.con_data}, 32'h41);
        @(negedge clk);
        check_eq("con_stall_hold", {24'b0, bus.con_data}, 32'h41);
        bus.con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("con_drain_valid", {31'b0, bus.con_valid}, 32'd1);
            check_eq("con_drain_data", {24'b0, bus.con_data}, 32'h41 + i);
            @(negedge clk);
        end
        bus.con_ready = 1'b0;
        rd(A_STATUS, v); check_eq("con_empty_ovf", v, 32'h0000_0006);
        check_eq("con_valid_empty", {31'b0, bus.con_valid}, 32'd0);
        wr(A_STATUS, 32'd0, 4'b0001);
        rd(A_STATUS, v); check_eq("con_ovf_clear", v, 32'h0000_0002);

        // full push + pop in the same cycle
        for (int i = 0; i < 8; i++) wr(A_CDATA, 32'h61 + i, 4'b0001);
        rd(A_STATUS, v); check_eq("con_refill", v, 32'h0000_0041);
        bus.con_ready = 1'b1;
        wr(A_CDATA, 32'h5A, 4'b0001);
        rd(A_STATUS, v); check_eq("con_pushpop_status", v, 32'h0000_0041);
        for (int i = 0; i < 7; i++) exp_b[i] = 8'h62 + 8'(i);
        exp_b[7] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("con_pp_data", {24'b0, bus.con_data}, {24'b0, exp_b[i]});
            @(negedge clk);
        end
        #1 check_eq("con_pp_empty", {31'b0, bus.con_valid}, 32'd0);
        bus.con_ready = 1'b0;

        // unmapped store
        check_eq("bus_err_idle", {31'b0, bus_err}, 32'd0);
        wr(32'h3000_0000, 32'h1234_5678, 4'b1111);
        check_eq("bus_err_pulse", {31'b0, bus_err}, 32'd1);
        rd(32'h3000_0000, v); check_eq("unmapped_read", v, 32'd0);
        @(negedge clk);
        check_eq("bus_err_one_cycle", {31'b0, bus_err}, 32'd0);

        // async reset mid-drain
        for (int i = 0; i < 3; i++) wr(A_CDATA, 32'h31 + i, 4'b0001);
        bus.con_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid_valid", {31'b0, bus.con_valid}, 32'd0);
        rd(A_MTLO, v);   check_eq("rst_mid_mtlo", v, 32'd0);
        rd(A_MTHI, v);   check_eq("rst_mid_mthi", v, 32'd0);
        rd(A_STATUS, v); check_eq("rst_mid_status", v, 32'h0000_0002);
        check_eq("rst_mid_irq", {31'b0, timer_irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.con_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
